irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Machine-mode interrupt controller for the Lexington core. It consumes the timer interrupt flag from the memory-mapped timer, plus software and external interrupt lines, and owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc and mcause. It raises a trap request to the pipeline through a req/ack handshake and supplies the trap and mret target PCs.

## Interface

Parameters:
- RESET_MTVEC, default 32'h0000_0000: mtvec value after reset.
- SYNC_STAGES, default 2: flop stages on the asynchronous external interrupt input; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- csr_rd_en  in  1  CSR read strobe
- csr_wr_en  in  1  CSR write strobe
- csr_addr  in  12  CSR address
- csr_wr_data  in  32  CSR write data (full word; set/clear resolved upstream)
- csr_rd_data  out  32  CSR read data
- mtip  in  1  timer interrupt flag (synchronous to clk)
- msip  in  1  software interrupt (synchronous)
- meip_async  in  1  external interrupt (asynchronous)
- pc_in  in  32  PC of the instruction to be interrupted, sampled at ack
- trap_req  out  1  trap request to pipeline
- trap_ack  in  1  pipeline accepts trap this cycle
- trap_pc  out  32  handler address, valid while trap_req
- mret  in  1  mret retiring this cycle
- mret_pc  out  32  current mepc

## Operation

- Decoded CSRs: mstatus 0x300 (bit 3 MIE, bit 7 MPIE; all other bits read 0), mie 0x304 (bits 3/7/11 writable), mtvec 0x305, mip 0x344 (read-only: bit 3 = msip, bit 7 = mtip, bit 11 = synchronized meip), mepc 0x341 (bits 1:0 forced to 0), mcause 0x342. Undecoded addresses read 0; writes to them are ignored.
- Read path is combinational. csr_rd_data = 0 when csr_rd_en is 0.
- Pending = mip & mie, gated by MIE. Priority order is MEI (cause 11), then MSI (3), then MTI (7).
- States:
  - IDLE: on a gated-pending interrupt, latch the cause and go to REQ.
  - REQ: trap_req=1, and trap_pc is computed from the latched cause. The request is not withdrawn if the source deasserts. On trap_ack: mepc<=pc_in, mcause<={1'b1,27'b0,cause}, MPIE<=MIE, MIE<=0, then go to IDLE.
- mret (accepted in any state): MIE<=MPIE, MPIE<=1.
- trap_pc = {mtvec[31:2],2'b00} in direct mode.

## Timing

- Reset values:
  - trap_req=0, state IDLE.
  - MIE=0, MPIE=0, mie=0.
  - mtvec=RESET_MTVEC, mepc=0, mcause=0.
  - Sync flops = 0.
- CSR writes take effect on the next clock edge.
- Latency from mtip/msip rising (with mie bit and MIE already set) to trap_req=1 is 1 cycle. For meip_async, add SYNC_STAGES cycles.
- trap_req stays high until a cycle with trap_ack=1. It drops the cycle after ack. Acks seen while in IDLE are ignored.
- A new request can form no earlier than the cycle after returning to IDLE. MIE=0 after ack, so a re-trap needs software or mret.
- Simultaneous events:
  - trap_ack and mret in the same cycle: ack wins, mret is ignored.
  - trap_ack and a CSR write to mstatus/mepc/mcause in the same cycle: ack updates win on the fields it touches.
  - CSR write clearing MIE while in REQ: the request still completes.
- rst_n low in REQ: next cycle is IDLE with trap_req=0.

## Configuration

- IRQ_VECTORED_EN defined:
  - mtvec[1:0] is writable with legal values 0 and 1; a write of 2 or 3 stores 0.
  - In mode 1, interrupt trap_pc = {mtvec[31:2],2'b00} + 4*cause.
- Undefined:
  - mtvec[1:0] is hardwired to 0 and reads 0.
  - Direct mode always.

## Test plan

- mtvec=0x100, mie=0x80, MIE=1, pulse mtip=1 -> trap_req the next cycle with trap_pc=0x100. Ack with pc_in=0x2004 -> mepc=0x2004, mcause=0x8000_0007, MIE=0, MPIE=1.
- msip, mtip and meip all high with mie=0x888 -> first trap has cause 11. After mret and re-ack, cause 3, then cause 7.
- With IRQ_VECTORED_EN, mtvec=0x101 and timer interrupt -> trap_pc=0x11C. Write mtvec=0x103 -> reads 0x100.
- mtip pulses high 1 cycle then drops while in REQ; ack delayed 5 cycles -> trap_req stays high throughout, and mcause=0x8000_0007 after ack.
- Trap_ack and mret in the same cycle -> MIE=0 and MPIE=previous MIE.
- Assert rst_n=0 while in REQ -> trap_req=0 next cycle and all CSRs return to their reset values.

Source files
------------

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause
// and raises trap requests through a req/ack handshake. `IRQ_VECTORED_EN enables vectored mtvec.
module irq_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_rd_en,
  input  logic        csr_wr_en,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wr_data,
  output logic [31:0] csr_rd_data,
  input  logic        mtip,
  input  logic        msip,
  input  logic        meip_async,
  input  logic [31:0] pc_in,
  output logic        trap_req,
  input  logic        trap_ack,
  output logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] mret_pc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Vectored builds keep only mode 0 or 1; anything else collapses to direct mode.
  function automatic logic [31:0] legal_mtvec(input logic [31:0] value);
`ifdef IRQ_VECTORED_EN
    return {value[31:2], 1'b0, (value[1:0] == 2'b01)};
`else
    return value & 32'hFFFF_FFFC;
`endif
  endfunction

  localparam logic [31:0] MTVEC_RST = legal_mtvec(RESET_MTVEC);

  logic [0:0]             state;
  logic [3:0]             cause_q;
  logic [SYNC_STAGES-1:0] meip_sync_q;
  logic                   meip_sync;
  logic                   status_mie;
  logic                   status_mpie;
  logic [31:0]            mie_q;
  logic [31:0]            mtvec_q;
  logic [31:0]            mepc_q;
  logic [31:0]            mcause_q;
  logic [31:0]            mip;
  logic [31:0]            pending;
  logic                   irq_valid;
  logic [3:0]             irq_cause;
  logic                   ack_fire;
  logic                   we_mstatus;
  logic                   we_mie;
  logic                   we_mtvec;
  logic                   we_mepc;
  logic                   we_mcause;
  logic [31:0]            trap_base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meip_sync_q <= '0;
    end else begin
      meip_sync_q <= {meip_sync_q[SYNC_STAGES-2:0], meip_async};
    end
  end

  assign meip_sync = meip_sync_q[SYNC_STAGES-1];
  assign mip       = {20'b0, meip_sync, 3'b0, mtip, 3'b0, msip, 3'b0};
  assign pending   = mip & mie_q & {32{status_mie}};

  // External wins over software, which wins over timer.
  always_comb begin
    irq_valid = 1'b0;
    irq_cause = 4'd0;
    if (pending[11]) begin
      irq_valid = 1'b1;
      irq_cause = 4'd11;
    end else if (pending[3]) begin
      irq_valid = 1'b1;
      irq_cause = 4'd3;
    end else if (pending[7]) begin
      irq_valid = 1'b1;
      irq_cause = 4'd7;
    end
  end

  assign ack_fire   = (state == ST_REQ) && trap_ack;
  assign we_mstatus = csr_wr_en && (csr_addr == ADDR_MSTATUS);
  assign we_mie     = csr_wr_en && (csr_addr == ADDR_MIE);
  assign we_mtvec   = csr_wr_en && (csr_addr == ADDR_MTVEC);
  assign we_mepc    = csr_wr_en && (csr_addr == ADDR_MEPC);
  assign we_mcause  = csr_wr_en && (csr_addr == ADDR_MCAUSE);

  // Once a request is raised it is held until acked, even if the source goes away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cause_q <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (irq_valid) begin
            state   <= ST_REQ;
            cause_q <= irq_cause;
          end
        end
        ST_REQ: begin
          if (trap_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign trap_req = (state == ST_REQ);

  // Trap entry outranks mret, which outranks a software write to mstatus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
    end else if (ack_fire) begin
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
    end else if (mret) begin
      status_mie  <= status_mpie;
      status_mpie <= 1'b1;
    end else if (we_mstatus) begin
      status_mie  <= csr_wr_data[3];
      status_mpie <= csr_wr_data[7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q   <= 32'h0;
      mtvec_q <= MTVEC_RST;
    end else begin
      if (we_mie) begin
        mie_q <= csr_wr_data & MIE_MASK;
      end
      if (we_mtvec) begin
        mtvec_q <= legal_mtvec(csr_wr_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
    end else if (ack_fire) begin
      mepc_q   <= pc_in & 32'hFFFF_FFFC;
      mcause_q <= {1'b1, 27'b0, cause_q};
    end else begin
      if (we_mepc) begin
        mepc_q <= csr_wr_data & 32'hFFFF_FFFC;
      end
      if (we_mcause) begin
        mcause_q <= csr_wr_data;
      end
    end
  end

  always_comb begin
    csr_rd_data = 32'h0;
    if (csr_rd_en) begin
      case (csr_addr)
        ADDR_MSTATUS: csr_rd_data = {24'b0, status_mpie, 3'b0, status_mie, 3'b0};
        ADDR_MIE:     csr_rd_data = mie_q;
        ADDR_MTVEC:   csr_rd_data = mtvec_q;
        ADDR_MEPC:    csr_rd_data = mepc_q;
        ADDR_MCAUSE:  csr_rd_data = mcause_q;
        ADDR_MIP:     csr_rd_data = mip;
        default:      csr_rd_data = 32'h0;
      endcase
    end
  end

  assign trap_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_pc = trap_base;
`ifdef IRQ_VECTORED_EN
    if (mtvec_q[0]) begin
      trap_pc = trap_base + {26'b0, cause_q, 2'b00};
    end
`endif
  end

  assign mret_pc = mepc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; vectored-mode steps build only with `IRQ_VECTORED_EN.
module tb_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        csr_rd_en;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        mtip;
  logic        msip;
  logic        meip_async;
  logic [31:0] pc_in;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] mret_pc;

  int checks;
  int failures;

  irq_ctrl #(
    .RESET_MTVEC(32'h0000_0040),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csr_rd_en  (csr_rd_en),
    .csr_wr_en  (csr_wr_en),
    .csr_addr   (csr_addr),
    .csr_wr_data(csr_wr_data),
    .csr_rd_data(csr_rd_data),
    .mtip       (mtip),
    .msip       (msip),
    .meip_async (meip_async),
    .pc_in      (pc_in),
    .trap_req   (trap_req),
    .trap_ack   (trap_ack),
    .trap_pc    (trap_pc),
    .mret       (mret),
    .mret_pc    (mret_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_req(input string tag, input logic expected);
    check_output(tag, {31'b0, trap_req}, {31'b0, expected});
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr,
                           input logic [31:0] expected);
    csr_addr  = addr;
    csr_rd_en = 1'b1;
    #1;
    check_output(tag, csr_rd_data, expected);
    csr_rd_en = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_wr_en   = 1'b1;
    csr_addr    = addr;
    csr_wr_data = data;
    tick();
    csr_wr_en   = 1'b0;
  endtask

  task automatic ack_trap(input logic [31:0] pc);
    pc_in    = pc;
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    csr_rd_en   = 1'b0;
    csr_wr_en   = 1'b0;
    csr_addr    = 12'h0;
    csr_wr_data = 32'h0;
    mtip        = 1'b0;
    msip        = 1'b0;
    meip_async  = 1'b0;
    pc_in       = 32'h0;
    trap_ack    = 1'b0;
    mret        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] reset values");
    check_req("rst_trap_req", 1'b0);
    check_csr("rst_mstatus", 12'h300, 32'h0);
    check_csr("rst_mie", 12'h304, 32'h0);
    check_csr("rst_mtvec", 12'h305, 32'h0000_0040);
    check_csr("rst_mepc", 12'h341, 32'h0);
    check_csr("rst_mcause", 12'h342, 32'h0);
    check_csr("rst_mip", 12'h344, 32'h0);
    csr_addr = 12'h305;
    #1;
    check_output("rd_en_low", csr_rd_data, 32'h0);

    $display("[TB] csr field masking");
    csr_write(12'h123, 32'hFFFF_FFFF);
    check_csr("undecoded", 12'h123, 32'h0);
    csr_write(12'h341, 32'h0000_1237);
    check_csr("mepc_mask", 12'h341, 32'h0000_1234);
    check_output("mret_pc", mret_pc, 32'h0000_1234);
    csr_write(12'h305, 32'h0000_0103);
    check_csr("mtvec_mode3", 12'h305, 32'h0000_0100);
    csr_write(12'h304, 32'hFFFF_FFFF);
    check_csr("mie_mask", 12'h304, 32'h0000_0888);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'hFFFF_FFFF);
    check_csr("mstatus_mask", 12'h300, 32'h0000_0088);
    csr_write(12'h300, 32'h0000_0008);

    $display("[TB] timer trap");
    mtip = 1'b1;
    #1;
    check_req("timer_not_yet", 1'b0);
    tick();
    mtip = 1'b0;
    check_req("timer_req", 1'b1);
    check_output("timer_trap_pc", trap_pc, 32'h0000_0100);
    ack_trap(32'h0000_2004);
    check_req("timer_req_drop", 1'b0);
    check_csr("timer_mepc", 12'h341, 32'h0000_2004);
    check_csr("timer_mcause", 12'h342, 32'h8000_0007);
    check_csr("timer_mstatus", 12'h300, 32'h0000_0080);
    check_output("timer_mret_pc", mret_pc, 32'h0000_2004);

    ack_trap(32'h000D_EAD0);
    check_csr("idle_ack_ignored", 12'h341, 32'h0000_2004);
    pulse_mret();
    check_csr("mret_mstatus", 12'h300, 32'h0000_0088);

    $display("[TB] request held across late ack");
    mtip = 1'b1;
    tick();
    mtip = 1'b0;
    check_req("held_req", 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_req("held_wait", 1'b1);
    end
    ack_trap(32'h0000_3000);
    check_req("held_drop", 1'b0);
    check_csr("held_mcause", 12'h342, 32'h8000_0007);
    check_csr("held_mepc", 12'h341, 32'h0000_3000);

    $display("[TB] priority");
    csr_write(12'h304, 32'h0000_0888);
    msip       = 1'b1;
    mtip       = 1'b1;
    meip_async = 1'b1;
    tick();
    tick();
    tick();
    check_csr("prio_mip", 12'h344, 32'h0000_0888);
    check_req("prio_masked", 1'b0);
    pulse_mret();
    tick();
    check_req("prio_req_mei", 1'b1);
    ack_trap(32'h0000_4000);
    check_csr("prio_cause_mei", 12'h342, 32'h8000_000B);
    meip_async = 1'b0;
    tick();
    tick();
    pulse_mret();
    tick();
    check_req("prio_req_msi", 1'b1);
    ack_trap(32'h0000_4100);
    check_csr("prio_cause_msi", 12'h342, 32'h8000_0003);
    msip = 1'b0;
    pulse_mret();
    tick();
    check_req("prio_req_mti", 1'b1);
    ack_trap(32'h0000_4200);
    check_csr("prio_cause_mti", 12'h342, 32'h8000_0007);

    $display("[TB] ack with mret and csr writes");
    pulse_mret();
    tick();
    check_req("coll_req", 1'b1);
    csr_write(12'h300, 32'h0000_0000);
    check_req("coll_mie_cleared_req", 1'b1);
    pc_in       = 32'h0000_5000;
    trap_ack    = 1'b1;
    mret        = 1'b1;
    csr_wr_en   = 1'b1;
    csr_addr    = 12'h341;
    csr_wr_data = 32'h0000_7778;
    tick();
    trap_ack  = 1'b0;
    mret      = 1'b0;
    csr_wr_en = 1'b0;
    mtip      = 1'b0;
    check_req("coll_drop", 1'b0);
    check_csr("coll_mstatus", 12'h300, 32'h0000_0000);
    check_csr("coll_mepc", 12'h341, 32'h0000_5000);

    $display("[TB] reset while requesting");
    csr_write(12'h300, 32'h0000_0008);
    mtip = 1'b1;
    tick();
    check_req("rstreq_req", 1'b1);
    rst_n = 1'b0;
    tick();
    mtip = 1'b0;
    check_req("rstreq_drop", 1'b0);
    check_csr("rstreq_mstatus", 12'h300, 32'h0);
    check_csr("rstreq_mie", 12'h304, 32'h0);
    check_csr("rstreq_mtvec", 12'h305, 32'h0000_0040);
    check_csr("rstreq_mepc", 12'h341, 32'h0);
    check_csr("rstreq_mcause", 12'h342, 32'h0);
    rst_n = 1'b1;
    tick();
    check_req("rstreq_idle", 1'b0);

    $display("[TB] external interrupt latency");
    csr_write(12'h304, 32'h0000_0800);
    csr_write(12'h300, 32'h0000_0008);
    meip_async = 1'b1;
    tick();
    check_req("meip_lat1", 1'b0);
    tick();
    check_req("meip_lat2", 1'b0);
    tick();
    check_req("meip_lat3", 1'b1);
    check_output("meip_trap_pc", trap_pc, 32'h0000_0040);
    ack_trap(32'h0000_6000);
    meip_async = 1'b0;
    check_csr("meip_mcause", 12'h342, 32'h8000_000B);

`ifdef IRQ_VECTORED_EN
    $display("[TB] vectored mode");
    tick();
    tick();
    csr_write(12'h305, 32'h0000_0101);
    check_csr("vec_mtvec", 12'h305, 32'h0000_0101);
    csr_write(12'h304, 32'h0000_0080);
    csr_write(12'h300, 32'h0000_0008);
    mtip = 1'b1;
    tick();
    mtip = 1'b0;
    check_req("vec_req", 1'b1);
    check_output("vec_trap_pc", trap_pc, 32'h0000_011C);
    ack_trap(32'h0000_7000);
    csr_write(12'h305, 32'h0000_0102);
    check_csr("vec_mode2", 12'h305, 32'h0000_0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
